// File: rtl/cgra_pkg.sv
// Shared constants and FSM state type for the CGRA context loader.
// The loader top is configured by the CGRA_CTX_REUSE_EN macro.
package cgra_pkg;

    localparam int unsigned CMEM_ADDR_W = 9;
    localparam int unsigned IMEM_LOG2   = 5;
    localparam int unsigned N_COL_DEF   = 4;

    // Kernel configuration word layout
    localparam int unsigned CONF_START_LSB = 0;
    localparam int unsigned CONF_START_MSB = CMEM_ADDR_W - 1;
    localparam int unsigned CONF_NL_LSB    = CMEM_ADDR_W;
    localparam int unsigned CONF_NL_MSB    = CMEM_ADDR_W + IMEM_LOG2 - 1;
    localparam int unsigned KER_N_COL_LB   = CMEM_ADDR_W + IMEM_LOG2;
    localparam int unsigned KER_N_COL_HB   = KER_N_COL_LB + N_COL_DEF - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KMEM,
        S_KDEC,
        S_STREAM,
        S_DRAIN,
        S_DONE,
        S_ERR
    } ctx_fsm_state_t;

endpackage

// File: rtl/cgra_nth_col_sel.sv
// Combinational selector: one-hot position of the idx-th set bit of mask,
// counting set bits in ascending index order.
module cgra_nth_col_sel
    import cgra_pkg::*;
#(
    parameter int unsigned N_COL = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_COL-1:0] mask,
    input  logic [IDX_W-1:0] idx,
    output logic [N_COL-1:0] col
);

    logic [IDX_W:0] seen;

    always_comb begin
        col  = '0;
        seen = '0;
        for (int unsigned i = 0; i < N_COL; i++) begin
            if (mask[i]) begin
                if (seen == {1'b0, idx}) begin
                    col[i] = 1'b1;
                end
                seen = seen + (IDX_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/cgra_context_loader.sv
// Loads a kernel's instruction lines from context memory into the granted
// columns' instruction memories. Optional reuse tag: CGRA_CTX_REUSE_EN.
module cgra_context_loader #(
    parameter int unsigned N_COL               = 4,
    parameter int unsigned N_ROW               = 4,
    parameter int unsigned INSTR_WIDTH         = 32,
    parameter int unsigned KMEM_WIDTH          = 32,
    parameter int unsigned KER_CONF_N_REG_LOG2 = 4,
    parameter int unsigned CMEM_ADDR_W         = cgra_pkg::CMEM_ADDR_W,
    parameter int unsigned IMEM_LOG2           = cgra_pkg::IMEM_LOG2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_COL-1:0]               acc_req_i,
    input  logic [KER_CONF_N_REG_LOG2-1:0] ker_id_i,
    output logic                           acc_ack_o,
    output logic [N_COL-1:0]               col_start_o,
    output logic                           kmem_rd_o,
    output logic [KER_CONF_N_REG_LOG2-1:0] kmem_addr_o,
    input  logic [KMEM_WIDTH-1:0]          kmem_data_i,
    output logic                           cmem_rd_o,
    output logic [CMEM_ADDR_W-1:0]         cmem_addr_o,
    input  logic [N_ROW*INSTR_WIDTH-1:0]   cmem_data_i,
    output logic [N_COL-1:0]               imem_we_o,
    output logic [IMEM_LOG2-1:0]           imem_addr_o,
    output logic [N_ROW*INSTR_WIDTH-1:0]   imem_data_o,
    input  logic                           ctx_inval_i,
    output logic                           busy_o,
    output logic                           err_o
);
    import cgra_pkg::*;

    localparam int unsigned IDX_W     = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int unsigned CNT_W     = $clog2(N_COL + 1);
    localparam int unsigned CONF_USED = KER_N_COL_LB + N_COL;

    function automatic logic [CNT_W-1:0] popcnt(input logic [N_COL-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N_COL; i++) begin
            c = c + CNT_W'(m[i]);
        end
        return c;
    endfunction

    ctx_fsm_state_t state_q, state_d;

    logic [N_COL-1:0]               mask_q;
    logic [KER_CONF_N_REG_LOG2-1:0] ker_q;
    logic [CMEM_ADDR_W-1:0]         start_q;
    logic [IMEM_LOG2-1:0]           nl_q;
    logic [CMEM_ADDR_W-1:0]         rd_cnt_q;
    logic [IMEM_LOG2-1:0]           line_q;
    logic [IDX_W-1:0]               col_q;
    logic                           wr_valid_q;
    logic [IMEM_LOG2-1:0]           wr_line_q;
    logic [IDX_W-1:0]               wr_col_q;
    logic [N_COL-1:0]               wr_col_onehot;
    logic                           last_rd;
    logic                           hit;
    logic                           unused_kmem;

    assign unused_kmem = ^kmem_data_i[KMEM_WIDTH-1:CONF_USED];

    // Line and column counters replace the k / lines and k mod lines division
    assign last_rd = (line_q == nl_q) &&
                     ((CNT_W'(col_q) + CNT_W'(1)) == popcnt(mask_q));

`ifdef CGRA_CTX_REUSE_EN
    logic                           tag_valid_q;
    logic [KER_CONF_N_REG_LOG2-1:0] tag_ker_q;
    logic [N_COL-1:0]               tag_mask_q;

    assign hit = tag_valid_q && (tag_ker_q == ker_id_i) && (tag_mask_q == acc_req_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || ctx_inval_i) begin
            tag_valid_q <= 1'b0;
            tag_ker_q   <= '0;
            tag_mask_q  <= '0;
        end else if (state_q == S_DONE) begin
            tag_valid_q <= 1'b1;
            tag_ker_q   <= ker_q;
            tag_mask_q  <= mask_q;
        end
    end
`else
    logic unused_inval;
    assign unused_inval = ctx_inval_i;
    assign hit          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        acc_ack_o   = 1'b0;
        col_start_o = '0;
        kmem_rd_o   = 1'b0;
        kmem_addr_o = '0;
        cmem_rd_o   = 1'b0;
        cmem_addr_o = '0;
        err_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|acc_req_i) begin
                    state_d = hit ? S_DONE : S_KMEM;
                end
            end
            S_KMEM: begin
                kmem_rd_o   = 1'b1;
                kmem_addr_o = ker_q;
                state_d     = S_KDEC;
            end
            S_KDEC: begin
                if ((ker_q == '0) ||
                    (popcnt(mask_q) != popcnt(kmem_data_i[KER_N_COL_LB +: N_COL]))) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                cmem_rd_o   = 1'b1;
                cmem_addr_o = start_q + rd_cnt_q;
                if (last_rd) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                acc_ack_o   = 1'b1;
                col_start_o = mask_q;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                acc_ack_o = 1'b1;
                err_o     = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            ker_q      <= '0;
            start_q    <= '0;
            nl_q       <= '0;
            rd_cnt_q   <= '0;
            line_q     <= '0;
            col_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_line_q  <= '0;
            wr_col_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= cmem_rd_o;
            wr_line_q  <= line_q;
            wr_col_q   <= col_q;
            case (state_q)
                S_IDLE: begin
                    if (|acc_req_i) begin
                        mask_q <= acc_req_i;
                        ker_q  <= ker_id_i;
                    end
                end
                S_KDEC: begin
                    start_q  <= kmem_data_i[CONF_START_LSB +: CMEM_ADDR_W];
                    nl_q     <= kmem_data_i[CONF_NL_LSB +: IMEM_LOG2];
                    rd_cnt_q <= '0;
                    line_q   <= '0;
                    col_q    <= '0;
                end
                S_STREAM: begin
                    rd_cnt_q <= rd_cnt_q + CMEM_ADDR_W'(1);
                    if (line_q == nl_q) begin
                        line_q <= '0;
                        col_q  <= col_q + IDX_W'(1);
                    end else begin
                        line_q <= line_q + IMEM_LOG2'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    cgra_nth_col_sel #(
        .N_COL (N_COL),
        .IDX_W (IDX_W)
    ) u_col_sel (
        .mask (mask_q),
        .idx  (wr_col_q),
        .col  (wr_col_onehot)
    );

    assign imem_we_o   = wr_valid_q ? wr_col_onehot : '0;
    assign imem_addr_o = wr_valid_q ? wr_line_q : '0;
    assign imem_data_o = wr_valid_q ? cmem_data_i : '0;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cgra_context_loader.sv
// Directed bench for cgra_context_loader: memory responders plus a scoreboard
// of expected context reads and instruction-memory writes.
module tb_cgra_context_loader;

    typedef enum int {M_LOAD, M_ERR, M_HIT} mode_t;

    typedef struct packed {
        logic [3:0]   we;
        logic [4:0]   addr;
        logic [127:0] data;
    } wr_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   acc_req_i;
    logic [3:0]   ker_id_i;
    logic         acc_ack_o;
    logic [3:0]   col_start_o;
    logic         kmem_rd_o;
    logic [3:0]   kmem_addr_o;
    logic [31:0]  kmem_data_i;
    logic         cmem_rd_o;
    logic [8:0]   cmem_addr_o;
    logic [127:0] cmem_data_i;
    logic [3:0]   imem_we_o;
    logic [4:0]   imem_addr_o;
    logic [127:0] imem_data_o;
    logic         ctx_inval_i;
    logic         busy_o;
    logic         err_o;

    logic [31:0]  kmem [16];
    logic [8:0]   exp_addr_q [$];
    wr_t          exp_wr_q [$];
    int           vectors = 0;
    int           miscompares = 0;
    int           rd_cnt = 0;
    int           kmem_cnt = 0;

    cgra_context_loader #(
        .N_COL               (4),
        .N_ROW               (4),
        .INSTR_WIDTH         (32),
        .KMEM_WIDTH          (32),
        .KER_CONF_N_REG_LOG2 (4),
        .CMEM_ADDR_W         (9),
        .IMEM_LOG2           (5)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .acc_req_i   (acc_req_i),
        .ker_id_i    (ker_id_i),
        .acc_ack_o   (acc_ack_o),
        .col_start_o (col_start_o),
        .kmem_rd_o   (kmem_rd_o),
        .kmem_addr_o (kmem_addr_o),
        .kmem_data_i (kmem_data_i),
        .cmem_rd_o   (cmem_rd_o),
        .cmem_addr_o (cmem_addr_o),
        .cmem_data_i (cmem_data_i),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_o (imem_data_o),
        .ctx_inval_i (ctx_inval_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] line_of(input logic [8:0] a);
        logic [31:0] w;
        w = {23'd0, a};
        return {32'hA000_0000 | w, 32'hB000_0000 | w, 32'hC000_0000 | w, 32'hD000_0000 | w};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responders: data one cycle after the strobe
    always @(posedge clk_i) begin
        if (kmem_rd_o) kmem_data_i <= kmem[kmem_addr_o];
        if (cmem_rd_o) cmem_data_i <= line_of(cmem_addr_o);
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (kmem_rd_o) kmem_cnt++;
            if (cmem_rd_o) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) begin
                    chk("cmem_unexpected", 1, 0);
                end else begin
                    chk("cmem_addr", cmem_addr_o, exp_addr_q.pop_front());
                end
            end
            if (imem_we_o != 4'b0000) begin
                chk("we_onehot", $onehot(imem_we_o), 1);
                if (exp_wr_q.size() == 0) begin
                    chk("imem_unexpected", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    chk("imem_we", imem_we_o, e.we);
                    chk("imem_addr", imem_addr_o, e.addr);
                    chk("imem_data", imem_data_o, e.data);
                end
            end
        end
    end

    task automatic push_expect(input logic [3:0] mask, input logic [8:0] start, input int nl);
        int lines, cols, c, ln, seen;
        logic [3:0] col;
        logic [8:0] a;
        wr_t e;
        lines = nl + 1;
        cols  = $countones(mask);
        for (int k = 0; k < cols * lines; k++) begin
            c = k / lines;
            ln = k % lines;
            col = 4'b0000;
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    if (seen == c) col[i] = 1'b1;
                    seen++;
                end
            end
            a = start + 9'(k);
            exp_addr_q.push_back(a);
            e.we = col;
            e.addr = 5'(ln);
            e.data = line_of(a);
            exp_wr_q.push_back(e);
        end
    endtask

    task automatic run_load(input string name, input logic [3:0] mask, input logic [3:0] kid,
                            input logic [8:0] start, input int nl, input logic [3:0] colf,
                            input logic [3:0] toggle, input mode_t mode);
        int n, exp_n, rd0, km0, w;
        bit got;
        kmem[kid] = {14'd0, colf, 5'(nl), start};
        w = $countones(mask) * (nl + 1);
        exp_n = (mode == M_LOAD) ? w + 4 : (mode == M_ERR) ? 3 : 1;
        if (mode == M_LOAD) push_expect(mask, start, nl);
        rd0 = rd_cnt;
        km0 = kmem_cnt;
        acc_req_i = mask;
        ker_id_i = kid;
        n = 0;
        got = 0;
        while (!got && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
            if (n == 1) chk({name, "_busy"}, busy_o, 1);
            if (toggle != 4'b0000 && n == 4) acc_req_i = toggle;
            if (acc_ack_o) got = 1;
        end
        chk({name, "_ack_seen"}, got, 1);
        if (got) begin
            chk({name, "_ack_cycle"}, n, exp_n);
            chk({name, "_err"}, err_o, (mode == M_ERR));
            chk({name, "_col_start"}, col_start_o, (mode == M_ERR) ? 4'b0000 : mask);
        end
        acc_req_i = 4'b0000;
        chk({name, "_cmem_reads"}, rd_cnt - rd0, (mode == M_LOAD) ? w : 0);
        chk({name, "_kmem_reads"}, kmem_cnt - km0, (mode == M_HIT) ? 0 : 1);
        chk({name, "_wr_left"}, exp_wr_q.size(), 0);
        @(posedge clk_i);
        #1;
        chk({name, "_idle_after"}, {busy_o, acc_ack_o, err_o}, 0);
        exp_addr_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) kmem[i] = '0;
        rst_i = 1'b1;
        acc_req_i = 4'b0000;
        ker_id_i = 4'd0;
        ctx_inval_i = 1'b0;
        kmem_data_i = '0;
        cmem_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_outs", {acc_ack_o, col_start_o, kmem_rd_o, kmem_addr_o, cmem_rd_o, cmem_addr_o,
                           imem_we_o, imem_addr_o, busy_o, err_o}, '0);
        chk("reset_data", imem_data_o, '0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        run_load("basic", 4'b0011, 4'd3, 9'h010, 2, 4'b0011, 4'b0000, M_LOAD);
        run_load("err_kid0", 4'b0011, 4'd0, 9'h020, 1, 4'b0011, 4'b0000, M_ERR);
        run_load("err_cnt", 4'b0101, 4'd2, 9'h030, 1, 4'b0111, 4'b0000, M_ERR);
`ifdef CGRA_CTX_REUSE_EN
        run_load("reuse_hit", 4'b0011, 4'd3, 9'h010, 2, 4'b0011, 4'b0000, M_HIT);
`else
        run_load("reuse_off", 4'b0011, 4'd3, 9'h010, 2, 4'b0011, 4'b0000, M_LOAD);
`endif
        ctx_inval_i = 1'b1;
        @(posedge clk_i);
        #1;
        ctx_inval_i = 1'b0;
        run_load("after_inval", 4'b0011, 4'd3, 9'h010, 2, 4'b0011, 4'b0000, M_LOAD);
        run_load("wrap", 4'b1001, 4'd7, 9'h1FF, 0, 4'b1001, 4'b0000, M_LOAD);
        run_load("toggle", 4'b0011, 4'd5, 9'h040, 3, 4'b0011, 4'b1100, M_LOAD);

        // Reset while streaming, with the request still held
        kmem[6] = {14'd0, 4'b1100, 5'd1, 9'h080};
        push_expect(4'b0110, 9'h080, 1);
        acc_req_i = 4'b0110;
        ker_id_i = 4'd6;
        repeat (5) begin
            @(posedge clk_i);
            #1;
        end
        chk("rst_mid_rd", cmem_rd_o, 1);
        chk("rst_mid_addr", cmem_addr_o, 9'h082);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_mid_outs", {acc_ack_o, col_start_o, kmem_rd_o, kmem_addr_o, cmem_rd_o, cmem_addr_o,
                             imem_we_o, imem_addr_o, busy_o, err_o}, '0);
        rst_i = 1'b0;
        exp_addr_q.delete();
        exp_wr_q.delete();
        run_load("restart", 4'b0110, 4'd6, 9'h080, 1, 4'b1100, 4'b0000, M_LOAD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
